// File: rtl/sd_spi_card_responder.sv
// sd_spi_card_responder: SPI-mode SD card emulator used as an on-chip
// loopback target. Decodes 48-bit command frames, answers R1/R3/R7, and
// streams a single 512-byte block from an external synchronous byte RAM
// for CMD17. All SPI-side inputs are oversampled on clk (clk >= 6x spi_clk).
module sd_spi_card_responder #(
  parameter int          MEM_ADDR_WIDTH = 10,
  parameter int          NCR_BYTES      = 1,
  parameter int          NAC_BYTES      = 2,
  parameter int          INIT_RETRIES   = 2,
  parameter logic [31:0] OCR_VALUE      = 32'hC0FF8000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cs_n,
  input  logic                      spi_clk,
  input  logic                      sd_data_in,
  output logic                      sd_data_out,
  output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [7:0]                mem_rd_data,
  output logic                      cmd_strobe,
  output logic [5:0]                cmd_index,
  output logic [31:0]               cmd_arg,
  output logic                      card_idle
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RX_ARG = 3'd1;
  localparam logic [2:0] S_NCR    = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_NAC    = 3'd4;
  localparam logic [2:0] S_DATA   = 3'd5;

  localparam logic [7:0] NCR_LAST = 8'(NCR_BYTES - 1);
  localparam logic [7:0] NAC_LAST = 8'(NAC_BYTES - 1);
  localparam logic [7:0] NAC_TOK  = 8'(NAC_BYTES);
  localparam logic [3:0] INIT_MAX = 4'(INIT_RETRIES);

  // synchronizers and edge detect
  logic [1:0] cs_s, sck_s, mosi_s;
  logic       sck_q;
  logic       cs_act, rise_evt, fall_evt;

  // framing
  logic [2:0] bit_cnt;
  logic [6:0] rx_sh;
  logic [7:0] rx_byte;
  logic       byte_done;

  // transmit path
  logic [7:0] tx_sh;
  logic [7:0] tx_next;
  logic       load_pend;
  logic       load_mem;

  // command FSM
  logic [2:0]  state;
  logic [7:0]  cnt;
  logic [9:0]  byte_idx;
  logic [5:0]  cmd_cur;
  logic [31:0] arg_sh;
  logic [39:0] resp_buf;
  logic [2:0]  resp_left;
  logic        send_data;
  logic        acmd_pending;
  logic [3:0]  init_cnt;

  // decode results
  logic [7:0]  dec_r1;
  logic [31:0] dec_ext;
  logic        dec_long, dec_data;
  logic        nxt_idle, nxt_acmd;
  logic [3:0]  nxt_init;

  // Two-flop synchronizers; cs resets deselected so nothing runs until it settles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_s   <= 2'b11;
      sck_s  <= 2'b00;
      mosi_s <= 2'b11;
      sck_q  <= 1'b0;
    end else begin
      cs_s   <= {cs_s[0], cs_n};
      sck_s  <= {sck_s[0], spi_clk};
      mosi_s <= {mosi_s[0], sd_data_in};
      sck_q  <= sck_s[1];
    end
  end

  assign cs_act    = ~cs_s[1];
  assign rise_evt  = cs_act &  sck_s[1] & ~sck_q;
  assign fall_evt  = cs_act & ~sck_s[1] &  sck_q;
  assign rx_byte   = {rx_sh, mosi_s[1]};
  assign byte_done = rise_evt & (bit_cnt == 3'd7);

  // Bit counter and MOSI shift register, realigned whenever cs drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= 3'd0;
      rx_sh   <= 7'd0;
    end else if (!cs_act) begin
      bit_cnt <= 3'd0;
    end else if (rise_evt) begin
      rx_sh   <= {rx_sh[5:0], mosi_s[1]};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // MISO shifter: the byte chosen at byte end loads on the next falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_sh     <= 8'hFF;
      load_pend <= 1'b0;
    end else if (!cs_act) begin
      tx_sh     <= 8'hFF;
      load_pend <= 1'b0;
    end else begin
      if (byte_done) load_pend <= 1'b1;
      if (fall_evt) begin
        if (load_pend) begin
          tx_sh     <= load_mem ? mem_rd_data : tx_next;
          load_pend <= 1'b0;
        end else begin
          tx_sh <= {tx_sh[6:0], 1'b1};
        end
      end
    end
  end

  assign sd_data_out = cs_s[1] | tx_sh[7];

  // Command decode: response bytes and next card state for the frame in hand.
  always_comb begin
    dec_r1   = {5'b0, 1'b1, 1'b0, card_idle};
    dec_ext  = 32'h0;
    dec_long = 1'b0;
    dec_data = 1'b0;
    nxt_idle = card_idle;
    nxt_init = init_cnt;
    nxt_acmd = 1'b0;
    case (cmd_cur)
      6'd0: begin
        nxt_idle = 1'b1;
        nxt_init = 4'd0;
        dec_r1   = 8'h01;
      end
      6'd8: begin
        dec_r1   = {7'b0, card_idle};
        dec_ext  = {16'h0, 4'h0, arg_sh[11:0]};
        dec_long = 1'b1;
      end
      6'd55: begin
        dec_r1   = {7'b0, card_idle};
        nxt_acmd = 1'b1;
      end
      6'd41: begin
        if (acmd_pending) begin
          if (init_cnt < INIT_MAX) begin
            nxt_init = init_cnt + 4'd1;
            dec_r1   = 8'h01;
          end else begin
            nxt_idle = 1'b0;
            dec_r1   = 8'h00;
          end
        end
      end
      6'd58: begin
        dec_r1   = {7'b0, card_idle};
        dec_ext  = OCR_VALUE;
        dec_long = 1'b1;
      end
      6'd17: begin
        if (card_idle) begin
          dec_r1 = 8'h05;
        end else begin
          dec_r1   = 8'h00;
          dec_data = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Byte-level FSM: at each byte end, pick the byte for the next slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= 8'd0;
      byte_idx     <= 10'd0;
      cmd_cur      <= 6'd0;
      arg_sh       <= 32'd0;
      resp_buf     <= 40'd0;
      resp_left    <= 3'd0;
      send_data    <= 1'b0;
      tx_next      <= 8'hFF;
      load_mem     <= 1'b0;
      mem_rd_addr  <= '0;
      cmd_strobe   <= 1'b0;
      cmd_index    <= 6'd0;
      cmd_arg      <= 32'd0;
      card_idle    <= 1'b1;
      acmd_pending <= 1'b0;
      init_cnt     <= 4'd0;
    end else begin
      cmd_strobe <= 1'b0;
      if (!cs_act) begin
        state    <= S_IDLE;
        tx_next  <= 8'hFF;
        load_mem <= 1'b0;
      end else if (byte_done) begin
        tx_next  <= 8'hFF;
        load_mem <= 1'b0;
        case (state)
          S_IDLE: begin
            if (rx_byte[7:6] == 2'b01) begin
              cmd_cur <= rx_byte[5:0];
              cnt     <= 8'd0;
              state   <= S_RX_ARG;
            end
          end
          S_RX_ARG: begin
            if (cnt == 8'd4) begin
              // CRC byte just ended: commit the command
              cmd_strobe   <= 1'b1;
              cmd_index    <= cmd_cur;
              cmd_arg      <= arg_sh;
              card_idle    <= nxt_idle;
              init_cnt     <= nxt_init;
              acmd_pending <= nxt_acmd;
              resp_buf     <= {dec_r1, dec_ext};
              resp_left    <= dec_long ? 3'd4 : 3'd0;
              send_data    <= dec_data;
              cnt          <= 8'd0;
              state        <= S_NCR;
            end else begin
              arg_sh <= {arg_sh[23:0], rx_byte};
              cnt    <= cnt + 8'd1;
            end
          end
          S_NCR: begin
            if (cnt == NCR_LAST) begin
              tx_next  <= resp_buf[39:32];
              resp_buf <= {resp_buf[31:0], 8'h00};
              state    <= S_RESP;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          S_RESP: begin
            if (resp_left != 3'd0) begin
              tx_next   <= resp_buf[39:32];
              resp_buf  <= {resp_buf[31:0], 8'h00};
              resp_left <= resp_left - 3'd1;
            end else if (send_data) begin
              cnt   <= 8'd0;
              state <= S_NAC;
            end else begin
              state <= S_IDLE;
            end
          end
          S_NAC: begin
            if (cnt == NAC_TOK) begin
              // token slot ended: first data byte comes from RAM
              byte_idx    <= 10'd0;
              mem_rd_addr <= {cmd_arg[MEM_ADDR_WIDTH-10:0], 9'd0};
              load_mem    <= 1'b1;
              state       <= S_DATA;
            end else begin
              if (cnt == NAC_LAST) tx_next <= 8'hFE;
              cnt <= cnt + 8'd1;
            end
          end
          S_DATA: begin
            // indices 0..511 are data slots, 512..513 the dummy CRC
            if (byte_idx < 10'd511) begin
              byte_idx    <= byte_idx + 10'd1;
              mem_rd_addr <= {cmd_arg[MEM_ADDR_WIDTH-10:0], byte_idx[8:0] + 9'd1};
              load_mem    <= 1'b1;
            end else if (byte_idx == 10'd513) begin
              state <= S_IDLE;
            end else begin
              byte_idx <= byte_idx + 10'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Bench for sd_spi_card_responder: a host driver issues SPI command
// transactions, a card model predicts every MISO byte and command strobe,
// and two monitors compare what the DUT produces against those queues.
module tb_sd_spi_card_responder;

  localparam int          MAW  = 10;
  localparam int          NCR  = 1;
  localparam int          NAC  = 2;
  localparam int          RETR = 2;
  localparam logic [31:0] OCR  = 32'hC0FF8000;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            cs_n = 1'b1;
  logic            spi_clk = 1'b0;
  logic            sd_data_in = 1'b1;
  logic            sd_data_out;
  logic [MAW-1:0]  mem_rd_addr;
  logic [7:0]      mem_rd_data = 8'h00;
  logic            cmd_strobe;
  logic [5:0]      cmd_index;
  logic [31:0]     cmd_arg;
  logic            card_idle;

  logic [7:0] ram [0:(1<<MAW)-1];

  sd_spi_card_responder #(
    .MEM_ADDR_WIDTH(MAW), .NCR_BYTES(NCR), .NAC_BYTES(NAC),
    .INIT_RETRIES(RETR), .OCR_VALUE(OCR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .spi_clk(spi_clk),
    .sd_data_in(sd_data_in), .sd_data_out(sd_data_out),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .cmd_strobe(cmd_strobe), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .card_idle(card_idle)
  );

  always #5 clk = ~clk;

  // synchronous byte RAM, one clk read latency
  always @(posedge clk) mem_rd_data <= ram[mem_rd_addr];

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        idle;
  } strb_t;

  logic [7:0] exp_q[$];
  strb_t      strb_q[$];
  logic [7:0] resp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // card model state
  bit m_idle = 1'b1;
  int m_init = 0;
  bit m_acmd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // What the card says to a command: R1, trailing bytes, optional block.
  task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [7:0] r1;
    int unsigned a;
    resp_q.delete();
    r1 = m_idle ? 8'h05 : 8'h04;
    case (idx)
      6'd0: begin m_idle = 1'b1; m_init = 0; r1 = 8'h01; end
      6'd8, 6'd55, 6'd58: r1 = m_idle ? 8'h01 : 8'h00;
      6'd41: if (m_acmd) begin
        if (m_init < RETR) begin m_init++; r1 = 8'h01; end
        else begin m_idle = 1'b0; r1 = 8'h00; end
      end
      6'd17: r1 = m_idle ? 8'h05 : 8'h00;
      default: ;
    endcase
    resp_q.push_back(r1);
    if (idx == 6'd8) begin
      resp_q.push_back(8'h00); resp_q.push_back(8'h00);
      resp_q.push_back({4'h0, arg[11:8]}); resp_q.push_back(arg[7:0]);
    end
    if (idx == 6'd58) begin
      resp_q.push_back(OCR[31:24]); resp_q.push_back(OCR[23:16]);
      resp_q.push_back(OCR[15:8]);  resp_q.push_back(OCR[7:0]);
    end
    if (idx == 6'd17 && r1 == 8'h00) begin
      repeat (NAC) resp_q.push_back(8'hFF);
      resp_q.push_back(8'hFE);
      for (int i = 0; i < 512; i++) begin
        a = ((arg << 9) + i) % (1 << MAW);
        resp_q.push_back(ram[a]);
      end
      resp_q.push_back(8'hFF); resp_q.push_back(8'hFF);
    end
    m_acmd = (idx == 6'd55);
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_init = 0; m_acmd = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sd_data_in = b[i];
      repeat (3) @(negedge clk);
      spi_clk = 1'b1;
      repeat (3) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  // nslots <= 0 sends enough filler to drain the whole response
  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input int nslots);
    logic [7:0] frame [6];
    logic [7:0] ex[$];
    int n;
    model_cmd(idx, arg);
    ex.delete();
    repeat (6 + NCR) ex.push_back(8'hFF);
    foreach (resp_q[i]) ex.push_back(resp_q[i]);
    n = (nslots <= 0) ? ex.size() + 1 : nslots;
    for (int i = 0; i < n; i++) exp_q.push_back(i < ex.size() ? ex[i] : 8'hFF);
    strb_q.push_back('{idx, arg, m_idle});
    frame[0] = {2'b01, idx};
    frame[1] = arg[31:24]; frame[2] = arg[23:16];
    frame[3] = arg[15:8];  frame[4] = arg[7:0];
    frame[5] = 8'h95;
    for (int i = 0; i < n; i++) spi_byte(i < 6 ? frame[i] : 8'hFF);
  endtask

  task automatic init_card();
    for (int i = 0; i <= RETR; i++) begin
      send_cmd(6'd55, 32'h0, 0);
      send_cmd(6'd41, 32'h40000000, 0);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_miso"},   {31'd0, sd_data_out}, 32'd1);
    check({tag, "_addr"},   {{(32-MAW){1'b0}}, mem_rd_addr}, 32'd0);
    check({tag, "_strobe"}, {31'd0, cmd_strobe}, 32'd0);
    check({tag, "_index"},  {26'd0, cmd_index}, 32'd0);
    check({tag, "_arg"},    cmd_arg, 32'd0);
    check({tag, "_idle"},   {31'd0, card_idle}, 32'd1);
  endtask

  // MISO monitor: assemble a byte per 8 host rising edges, compare in order
  initial begin : miso_mon
    logic [7:0] sh;
    int nb;
    sh = 8'h00;
    nb = 0;
    forever begin
      @(posedge spi_clk or posedge cs_n);
      if (cs_n) begin
        nb = 0;
      end else begin
        sh = {sh[6:0], sd_data_out};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL miso_unexpected: got %h, expected no byte", sh);
          end else begin
            check("miso_byte", {24'd0, sh}, {24'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  // command strobe monitor: index, argument and resulting idle bit
  initial begin : strobe_mon
    strb_t e;
    forever begin
      @(negedge clk);
      if (reset_n && cmd_strobe) begin
        if (strb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL strobe_unexpected: got index %0d, expected none", cmd_index);
        end else begin
          e = strb_q.pop_front();
          check("strobe_index", {26'd0, cmd_index}, {26'd0, e.idx});
          check("strobe_arg", cmd_arg, e.arg);
          check("strobe_idle", {31'd0, card_idle}, {31'd0, e.idle});
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int r;
    logic [5:0] idx;
    for (int i = 0; i < (1 << MAW); i++) ram[i] = 8'($urandom);

    repeat (4) @(negedge clk);
    check_reset("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(8'hFF);
      spi_byte(8'hFF);
    end
    send_cmd(6'd0, 32'h0, 0);
    send_cmd(6'd8, 32'h000001AA, 0);
    send_cmd(6'd41, 32'h40000000, 0);
    init_card();
    send_cmd(6'd41, 32'h40000000, 0);
    send_cmd(6'd58, 32'h0, 0);
    send_cmd(6'd17, 32'h1, 0);

    // block read refused while idle: no token over 600 bytes
    send_cmd(6'd0, 32'h0, 0);
    send_cmd(6'd17, $urandom, 6 + NCR + 1 + 600);

    // abort a block read after 100 data bytes
    init_card();
    send_cmd(6'd17, $urandom, 6 + NCR + 1 + NAC + 1 + 100);
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      spi_clk = 1'b1;
      @(negedge clk);
      check("miso_deselected", {31'd0, sd_data_out}, 32'd1);
      repeat (2) @(negedge clk);
      spi_clk = 1'b0;
      repeat (3) @(negedge clk);
    end
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_cmd(6'd0, 32'h0, 0);

    // random command mix; block reads only while the model says idle
    for (int k = 0; k < 8; k++) begin
      r = $urandom_range(6);
      case (r)
        0: idx = 6'd0;
        1: idx = 6'd8;
        2: idx = 6'd55;
        3: idx = 6'd41;
        4: idx = 6'd58;
        5: idx = 6'd17;
        default: idx = 6'($urandom_range(63));
      endcase
      if (idx == 6'd17 && !m_idle) idx = 6'd58;
      send_cmd(idx, $urandom, 0);
    end

    // reset in the middle of an R7
    send_cmd(6'd8, $urandom, 6 + NCR + 2);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("midreset");
    model_reset();
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    send_cmd(6'd0, 32'h0, 0);

    repeat (20) @(negedge clk);
    check("miso_queue_left", exp_q.size(), 32'd0);
    check("strobe_queue_left", strb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
